regset_mp: RTL and testbench

//  Parametrised multi-read-port register file for pipelined cores; successor to the 2R1W regset.
//  - Width, depth, read-port count and the hardwired-zero register are parameters.
//  - Adds a per-register pending scoreboard for hazard detection.
//  - Reset is a sequenced clear, one register per cycle, signalled on BUSY, instead of a one-cycle flash clear.

---
 rtl/regset_pkg.sv | 17 +
 rtl/regset_clear_seq.sv | 54 +++++
 rtl/regset_mp.sv | 105 ++++++++++
 tb/tb_regset_mp.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/regset_pkg.sv
// Shared definitions for the multi-read-port register set: sweep states and sizing helpers.
package regset_pkg;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Address width for a register count, never narrower than one bit.
    function automatic int unsigned aw_of(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Low bit of a read port's slice within a packed multi-port bus.
    function automatic int unsigned port_lsb(input int unsigned port, input int unsigned w);
        return port * w;
    endfunction

endpackage

// File: rtl/regset_clear_seq.sv
// Clear sequencer: after reset it sweeps the register array one entry per cycle
// and reports BUSY until the final entry has been zeroed.
module regset_clear_seq
    import regset_pkg::*;
#(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned AW       = 5
) (
    input  logic          clk,
    input  logic          res,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= ST_CLEAR;
            ptr_q   <= AW'(ZERO_REG);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Advance the sweep pointer; the last register is cleared in the cycle we leave CLEAR.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == AW'(NREGS - 1)) begin
                    state_d = ST_READY;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            ST_READY: ;
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = AW'(ZERO_REG);
            end
        endcase
    end

    assign busy     = (state_q != ST_READY);
    assign clr_we   = busy;
    assign clr_addr = ptr_q;

endmodule

// File: rtl/regset_mp.sv
// Multi-read-port register set with pending scoreboard and sequenced clear.
// Optional same-cycle write-to-read forwarding is enabled by defining REGSET_BYPASS_EN.
module regset_mp
    import regset_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = aw_of(NREGS)
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic [XLEN-1:0]     D,
    input  logic [AW-1:0]       A_D,
    input  logic                write_enable,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic [NRD*AW-1:0]   A_Q,
    output logic [NRD*XLEN-1:0] Q,
    output logic [NRD-1:0]      PEND,
    output logic                BUSY
);

    logic [XLEN-1:0]  data_q [NREGS];
    logic [XLEN-1:0]  data_d [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic             wr_ok;
    logic             rsv_ok;

    function automatic logic legal(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    regset_clear_seq #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_clear_seq (
        .clk      (CLK),
        .res      (RES),
        .busy     (BUSY),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Updates are only accepted when ready and not being reset on this edge.
    assign wr_ok  = !BUSY && !RES && write_enable && legal(A_D);
    assign rsv_ok = !BUSY && !RES && rsv_en && legal(rsv_addr);

    always_comb begin
        data_d = data_q;
        pend_d = pend_q;
        if (BUSY) begin
            if (clr_we) begin
                data_d[clr_addr] = '0;
            end
        end else begin
            if (wr_ok) begin
                data_d[A_D] = D;
                pend_d[A_D] = 1'b0;
            end
            // Reservation after writeback so a new producer wins on a shared edge.
            if (rsv_ok) begin
                pend_d[rsv_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        data_q <= data_d;
        if (RES) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Combinational read ports, zeroed while busy or for illegal addresses.
    always_comb begin
        logic [AW-1:0] ra;
        Q    = '0;
        PEND = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            ra = A_Q[port_lsb(k, AW) +: AW];
            if (!BUSY && legal(ra)) begin
`ifdef REGSET_BYPASS_EN
                if (wr_ok && (A_D == ra)) begin
                    Q[port_lsb(k, XLEN) +: XLEN] = D;
                    PEND[k] = rsv_ok && (rsv_addr == A_D);
                end else begin
                    Q[port_lsb(k, XLEN) +: XLEN] = data_q[ra];
                    PEND[k] = pend_q[ra];
                end
`else
                Q[port_lsb(k, XLEN) +: XLEN] = data_q[ra];
                PEND[k] = pend_q[ra];
`endif
            end
        end
    end

endmodule

// File: tb/tb_regset_mp.sv
// Directed bench for regset_mp: a 32-entry and a 24-entry instance share all inputs.
module tb_regset_mp;

    localparam int unsigned AW = 5;

    logic            clk = 1'b0;
    logic            res;
    logic [31:0]     d;
    logic [AW-1:0]   a_d;
    logic            we;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic [4*AW-1:0] a_q;
    logic [127:0]    q32, q24;
    logic [3:0]      pend32, pend24;
    logic            busy32, busy24;

    int n_chk  = 0;
    int n_fail = 0;

    regset_mp #(.XLEN(32), .NREGS(32), .NRD(4), .ZERO_REG(1)) u_dut32 (
        .CLK(clk), .RES(res), .D(d), .A_D(a_d), .write_enable(we),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .A_Q(a_q),
        .Q(q32), .PEND(pend32), .BUSY(busy32)
    );

    regset_mp #(.XLEN(32), .NREGS(24), .NRD(4), .ZERO_REG(1)) u_dut24 (
        .CLK(clk), .RES(res), .D(d), .A_D(a_d), .write_enable(we),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .A_Q(a_q),
        .Q(q24), .PEND(pend24), .BUSY(busy24)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_aq(input int p0, input int p1, input int p2, input int p3);
        a_q = {AW'(p3), AW'(p2), AW'(p1), AW'(p0)};
    endtask

    // Count cycles each instance reports BUSY, bounded so a stuck sweep still terminates.
    task automatic count_busy(output int c32, output int c24);
        c32 = 0;
        c24 = 0;
        for (int i = 0; i < 100 && (busy32 || busy24); i++) begin
            if (busy32) c32++;
            if (busy24) c24++;
            step();
        end
    endtask

    int c32, c24;

    initial begin
        res = 1'b1; d = '0; a_d = '0; we = 1'b0; rsv_en = 1'b0; rsv_addr = '0;
        set_aq(0, 5, 7, 31);

        // Reset and sweep length
        step();
        res = 1'b0;
        chk("busy_after_res", 64'(busy32), 64'd1);
        chk("q_zero_busy", 64'(q32[31:0]), 64'd0);
        count_busy(c32, c24);
        chk("busy_len_32", 64'(c32), 64'd31);
        chk("busy_len_24", 64'(c24), 64'd23);
        chk("q_all_zero", 64'(q32 != '0), 64'd0);
        chk("pend_all_zero", 64'(pend32), 64'd0);

        // Write x5, read x5 and x0; write to x0 is dropped
        we = 1'b1; a_d = 5; d = 32'hDEADBEEF;
        set_aq(5, 0, 5, 0);
        step();
        we = 1'b0;
        chk("x5_read", 64'(q32[31:0]), 64'hDEADBEEF);
        chk("x0_read", 64'(q32[63:32]), 64'd0);
        chk("x5_read_p2", 64'(q32[95:64]), 64'hDEADBEEF);
        we = 1'b1; a_d = 0; d = 32'hFFFFFFFF;
        step();
        we = 1'b0;
        chk("x0_after_write", 64'(q32[63:32]), 64'd0);
        chk("x0_pend", 64'(pend32[1]), 64'd0);

        // Scoreboard: reserve, writeback, then both on one edge
        set_aq(7, 5, 0, 0);
        rsv_en = 1'b1; rsv_addr = 7;
        step();
        rsv_en = 1'b0;
        chk("x7_pend_set", 64'(pend32[0]), 64'd1);
        chk("x5_not_pend", 64'(pend32[1]), 64'd0);
        we = 1'b1; a_d = 7; d = 32'h12;
        step();
        we = 1'b0;
        chk("x7_pend_clr", 64'(pend32[0]), 64'd0);
        chk("x7_data", 64'(q32[31:0]), 64'h12);
        we = 1'b1; a_d = 7; d = 32'h12; rsv_en = 1'b1; rsv_addr = 7;
        step();
        we = 1'b0; rsv_en = 1'b0;
        chk("x7_rsv_wins", 64'(pend32[0]), 64'd1);
        chk("x7_data_both", 64'(q32[31:0]), 64'h12);

        // Same-cycle write and read of x3
        set_aq(3, 0, 0, 0);
        we = 1'b1; a_d = 3; d = 32'hA5;
        #1;
`ifdef REGSET_BYPASS_EN
        chk("x3_same_cycle", 64'(q32[31:0]), 64'hA5);
`else
        chk("x3_same_cycle", 64'(q32[31:0]), 64'd0);
`endif
        step();
        we = 1'b0;
        chk("x3_after_edge", 64'(q32[31:0]), 64'hA5);

        // Reset restarted mid-sweep; writes during the sweep are dropped
        set_aq(5, 7, 3, 0);
        res = 1'b1;
        step();
        res = 1'b0;
        we = 1'b1; a_d = 5; d = 32'h1234;
        for (int i = 0; i < 10; i++) step();
        chk("busy_mid_clear", 64'(busy32), 64'd1);
        res = 1'b1;
        step();
        res = 1'b0;
        count_busy(c32, c24);
        we = 1'b0;
        chk("busy_restart_32", 64'(c32), 64'd31);
        chk("x5_dropped", 64'(q32[31:0]), 64'd0);
        chk("x7_pend_reset", 64'(pend32[1]), 64'd0);
        chk("x3_cleared", 64'(q32[95:64]), 64'd0);

        // Four ports: three at x9 and one at x30 (out of range for 24 entries)
        we = 1'b1; a_d = 9; d = 32'h9999;
        step();
        we = 1'b0;
        rsv_en = 1'b1; rsv_addr = 30;
        step();
        rsv_addr = 9;
        step();
        rsv_en = 1'b0;
        set_aq(9, 9, 9, 30);
        #1;
        chk("p0_x9_24", 64'(q24[31:0]), 64'h9999);
        chk("p1_x9_24", 64'(q24[63:32]), 64'h9999);
        chk("p2_x9_24", 64'(q24[95:64]), 64'h9999);
        chk("p3_oor_q_24", 64'(q24[127:96]), 64'd0);
        chk("pend_24", 64'(pend24), 64'b0111);
        chk("p3_x30_q_32", 64'(q32[127:96]), 64'd0);
        chk("pend_32", 64'(pend32), 64'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
